otter_io_periph: RTL
====================

Name: otter_io_periph

Overview:
- Memory-mapped I/O peripheral block that sits directly downstream of the pipelined Otter core's IOBUS.
- Consumes IOBUS_ADDR/IOBUS_OUT/IOBUS_WR from the M stage.
- Returns read data on IOBUS_IN and drives the core's INTR input.
- Holds board-facing registers: switches, buttons, LEDs and seven-segment value, plus a programmable down-counting timer and an interrupt controller.

Parameters:
- BASE_ADDR, 32'h1100_0000, base of the 256-byte I/O window; only IOBUS_ADDR[31:8] is compared.
- SW_WIDTH, 16, switch input width.
- BTN_WIDTH, 4, button input width.
- LED_WIDTH, 16, LED output width.

Ports:
- CLK  input  1  system clock
- RST  input  1  asynchronous active-high reset
- IOBUS_ADDR  input  32  byte address from core M stage
- IOBUS_OUT  input  32  write data from core
- IOBUS_WR  input  1  word write strobe, one cycle per store
- IOBUS_IN  output  32  registered read data to core
- INTR  output  1  registered interrupt request to core
- SWITCHES  input  SW_WIDTH  asynchronous board switches
- BUTTONS  input  BTN_WIDTH  asynchronous board buttons
- LEDS  output  LED_WIDTH  LED register
- SSEG_VAL  output  16  value for the seven-segment driver

Behaviour:
- Reset: one clock; RST asynchronous, active-high. All registers, IOBUS_IN, INTR, LEDS and SSEG_VAL clear to 0 immediately on RST. Synchronizers clear to 0.
- Address hit: IOBUS_ADDR[31:8]==BASE_ADDR[31:8].
  - Offset is IOBUS_ADDR[7:0]; bits [1:0] are ignored (word access only).
  - Misses and unmapped offsets read 0; writes to them are ignored.
- Register map (offset, access, content):
  - 0x00 RO: SWITCHES, 2-flop synchronized, zero-extended.
  - 0x04 RO: BUTTONS, 2-flop synchronized, zero-extended.
  - 0x20 RW: LEDS[LED_WIDTH-1:0].
  - 0x40 RW: SSEG_VAL[15:0].
  - 0x60 RW: TCTRL. bit0 EN, bit1 AUTO; other bits read 0.
  - 0x64 RW: TLOAD[31:0].
  - 0x68 RO: TCOUNT[31:0].
  - 0x6C RW1C: IRQ_PEND. bit0 timer, bit1 button.
  - 0x70 RW: IRQ_EN. bit0 timer, bit1 button.
- Writes: take effect on the CLK edge on which IOBUS_WR=1 with a hit. Read-back is visible from the next cycle.
- Read latency: IOBUS_IN is registered every cycle from the current IOBUS_ADDR. Data is valid exactly 1 cycle after the address, matching synchronous data-memory latency. Reads have no side effects.
- Timer:
  - A write of TCTRL that sets EN from 0 to 1 loads TCOUNT<=TLOAD on the same edge.
  - While EN=1 and TCOUNT!=0: TCOUNT decrements by 1 per cycle.
  - While EN=1 and TCOUNT==0: IRQ_PEND[0] is set, then:
    - AUTO=1: TCOUNT<=TLOAD.
    - AUTO=0: EN<=0 and TCOUNT holds at 0.
  - TLOAD==0 with EN=1 and AUTO=1 sets pending every cycle.
  - A write to TLOAD while running does not alter TCOUNT; it takes effect at the next reload.
  - A write of EN=0 stops the counter; TCOUNT holds its value.
- Button IRQ: IRQ_PEND[1] is set on a rising edge of any synchronized button bit, using a registered previous value.
- IRQ_PEND clear: writing 1 to a bit clears it. If a hardware set and a software clear land on the same edge, the set wins.
- INTR: register of |(IRQ_PEND & IRQ_EN[1:0]), so it lags pending by 1 cycle. INTR stays high until software clears or disables the source.
- Reset mid-count: the timer stops and EN=0. A pending interrupt is lost; no spurious INTR follows reset release.
- Simultaneous EN 0-to-1 write and count==0 condition: the load takes priority and no pending bit is set that cycle.

Decomposition:
- otter_io_pkg:
  - Register offset localparams: OFF_SW, OFF_BTN, OFF_LED, OFF_SSEG, OFF_TCTRL, OFF_TLOAD, OFF_TCOUNT, OFF_IRQPEND, OFF_IRQEN.
  - TCTRL and IRQ bit-index constants.
- Sub-module io_timer:
  - Inputs: CLK, RST, en_set/en_clr, auto, load value.
  - Outputs: count, en, expire pulse.
- The top handles decode, synchronizers, the IRQ controller and the read mux.

Test Plan:
- Reset: assert RST mid-operation → all outputs, including IOBUS_IN and INTR, read 0 at once, with no clock edge needed.
- LED and miss: write 0x0000_A5A5 to 0x1100_0020 → LEDS=0xA5A5; read returns 0xA5A5 one cycle later. A write to 0x1200_0020 leaves LEDS unchanged and reading it returns 0.
- Switch sync: SWITCHES=0x1234 → a read of 0x1100_0000 returns 0x0000_1234 within 3 cycles of the change.
- One-shot timer:
  - Setup: TLOAD=5, IRQ_EN=1, TCTRL=0x1.
  - TCOUNT reads 5,4,3,2,1,0 on successive cycles.
  - IRQ_PEND=1, INTR=1 one cycle later, EN reads 0.
  - Writing 0x1 to 0x6C drops INTR the cycle after.
- Auto-reload: TLOAD=2, TCTRL=0x3 → pending set every 3 cycles. Clearing it on the same edge as an expiry leaves pending=1.
- Button IRQ: IRQ_EN=2, BUTTONS 0→0x4 → IRQ_PEND=0x2, and INTR rises 4 cycles after the input edge (2 sync, 1 edge detect, 1 INTR register). Holding the button causes no re-trigger after clear.

Source files
------------

// File: rtl/otter_io_pkg.sv
// Shared register map and bit positions for the Otter memory-mapped I/O block.
package otter_io_pkg;

    localparam logic [7:0] OFF_SW      = 8'h00;
    localparam logic [7:0] OFF_BTN     = 8'h04;
    localparam logic [7:0] OFF_LED     = 8'h20;
    localparam logic [7:0] OFF_SSEG    = 8'h40;
    localparam logic [7:0] OFF_TCTRL   = 8'h60;
    localparam logic [7:0] OFF_TLOAD   = 8'h64;
    localparam logic [7:0] OFF_TCOUNT  = 8'h68;
    localparam logic [7:0] OFF_IRQPEND = 8'h6C;
    localparam logic [7:0] OFF_IRQEN   = 8'h70;

    localparam int TCTRL_EN   = 0;
    localparam int TCTRL_AUTO = 1;

    localparam int IRQ_TIMER = 0;
    localparam int IRQ_BTN   = 1;

endpackage

// File: rtl/otter_io_periph_timer.sv
// Programmable down-counter: loads on enable, raises expire at zero, then reloads or stops.
module io_timer
    import otter_io_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        enSet,
    input  logic        enClr,
    input  logic        autoMode,
    input  logic [31:0] loadVal,
    output logic [31:0] count,
    output logic        en,
    output logic        expire
);

    // A stop request on the expiry edge suppresses the expiry.
    assign expire = en && (count == 32'd0) && !enClr;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= 32'd0;
            en    <= 1'b0;
        end else if (enSet && !en) begin
            count <= loadVal;
            en    <= 1'b1;
        end else if (enClr) begin
            en <= 1'b0;
        end else if (en) begin
            if (count != 32'd0) begin
                count <= count - 32'd1;
            end else if (autoMode) begin
                count <= loadVal;
            end else begin
                en <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/otter_io_periph.sv
// Otter IOBUS peripheral: board registers, timer, interrupt controller and registered read mux.
module otter_io_periph
    import otter_io_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1100_0000,
    parameter int          SW_WIDTH  = 16,
    parameter int          BTN_WIDTH = 4,
    parameter int          LED_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [31:0]          IOBUS_ADDR,
    input  logic [31:0]          IOBUS_OUT,
    input  logic                 IOBUS_WR,
    output logic [31:0]          IOBUS_IN,
    output logic                 INTR,
    input  logic [SW_WIDTH-1:0]  SWITCHES,
    input  logic [BTN_WIDTH-1:0] BUTTONS,
    output logic [LED_WIDTH-1:0] LEDS,
    output logic [15:0]          SSEG_VAL
);

    logic                 hit;
    logic                 wrHit;
    logic [7:0]           offset;
    logic [SW_WIDTH-1:0]  swMeta;
    logic [SW_WIDTH-1:0]  swSync;
    logic [BTN_WIDTH-1:0] btnMeta;
    logic [BTN_WIDTH-1:0] btnSync;
    logic [BTN_WIDTH-1:0] btnPrev;
    logic                 btnRise;
    logic                 autoReg;
    logic [31:0]          tload;
    logic [31:0]          tCount;
    logic                 tEn;
    logic                 tExpire;
    logic                 enSet;
    logic                 enClr;
    logic [1:0]           pend;
    logic [1:0]           irqEn;
    logic [1:0]           pendSet;
    logic [1:0]           pendClr;
    logic [31:0]          rdNext;
    logic                 unusedAddr;

    assign hit        = (IOBUS_ADDR[31:8] == BASE_ADDR[31:8]);
    assign wrHit      = IOBUS_WR && hit;
    assign offset     = {IOBUS_ADDR[7:2], 2'b00};
    assign unusedAddr = ^IOBUS_ADDR[1:0];

    assign enSet   = wrHit && (offset == OFF_TCTRL) && IOBUS_OUT[TCTRL_EN];
    assign enClr   = wrHit && (offset == OFF_TCTRL) && !IOBUS_OUT[TCTRL_EN];
    assign btnRise = |(btnSync & ~btnPrev);

    always_comb begin
        pendSet            = 2'b00;
        pendSet[IRQ_TIMER] = tExpire;
        pendSet[IRQ_BTN]   = btnRise;
        pendClr            = (wrHit && (offset == OFF_IRQPEND)) ? IOBUS_OUT[1:0] : 2'b00;
    end

    io_timer uTimer (
        .CLK      (CLK),
        .RST      (RST),
        .enSet    (enSet),
        .enClr    (enClr),
        .autoMode (autoReg),
        .loadVal  (tload),
        .count    (tCount),
        .en       (tEn),
        .expire   (tExpire)
    );

    always_comb begin
        rdNext = 32'd0;
        if (hit) begin
            case (offset)
                OFF_SW:      rdNext = 32'(swSync);
                OFF_BTN:     rdNext = 32'(btnSync);
                OFF_LED:     rdNext = 32'(LEDS);
                OFF_SSEG:    rdNext = {16'd0, SSEG_VAL};
                OFF_TCTRL:   rdNext = {30'd0, autoReg, tEn};
                OFF_TLOAD:   rdNext = tload;
                OFF_TCOUNT:  rdNext = tCount;
                OFF_IRQPEND: rdNext = {30'd0, pend};
                OFF_IRQEN:   rdNext = {30'd0, irqEn};
                default:     rdNext = 32'd0;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            swMeta   <= '0;
            swSync   <= '0;
            btnMeta  <= '0;
            btnSync  <= '0;
            btnPrev  <= '0;
            IOBUS_IN <= 32'd0;
            INTR     <= 1'b0;
            pend     <= 2'b00;
            irqEn    <= 2'b00;
            LEDS     <= '0;
            SSEG_VAL <= 16'd0;
            autoReg  <= 1'b0;
            tload    <= 32'd0;
        end else begin
            swMeta   <= SWITCHES;
            swSync   <= swMeta;
            btnMeta  <= BUTTONS;
            btnSync  <= btnMeta;
            btnPrev  <= btnSync;
            IOBUS_IN <= rdNext;
            INTR     <= |(pend & irqEn);
            // Hardware set is applied after the clear so it wins on a collision.
            pend     <= (pend & ~pendClr) | pendSet;
            if (wrHit) begin
                case (offset)
                    OFF_LED:   LEDS     <= IOBUS_OUT[LED_WIDTH-1:0];
                    OFF_SSEG:  SSEG_VAL <= IOBUS_OUT[15:0];
                    OFF_TCTRL: autoReg  <= IOBUS_OUT[TCTRL_AUTO];
                    OFF_TLOAD: tload    <= IOBUS_OUT;
                    OFF_IRQEN: irqEn    <= IOBUS_OUT[1:0];
                    default:   ;
                endcase
            end
        end
    end

endmodule
